// File: rtl/msrh_rename_ckpt_map_pkg.sv
// Shared constants, map type and forwarding helper for the rename map with checkpoint recovery.
package msrh_rename_ckpt_map_pkg;

  localparam int MSRH_DISP_SIZE  = 2;
  localparam int MSRH_RNID_W     = 7;
  localparam int MSRH_ARCH_NUM   = 32;
  localparam int MSRH_REG_W      = 5;
  localparam int MSRH_CKPT_DEPTH = 4;
  localparam int MSRH_CKPT_W     = $clog2(MSRH_CKPT_DEPTH);

  typedef logic [MSRH_RNID_W-1:0] rn_map_t [MSRH_ARCH_NUM];

  // True when an older slot's destination supplies the value for src_regidx; x0 never forwards.
  function automatic logic rn_fwd_lookup(input logic                  rd_valid,
                                         input logic [MSRH_REG_W-1:0] rd_regidx,
                                         input logic [MSRH_REG_W-1:0] src_regidx);
    return rd_valid && (rd_regidx != '0) && (rd_regidx == src_regidx);
  endfunction

endpackage

// File: rtl/msrh_rename_ckpt_ring.sv
// Ring of full-map checkpoints with head/tail/count tracking, truncation on mispredict
// and reset to empty on full flush. CKPT_DEPTH must be a power of two.
module msrh_rename_ckpt_ring
  import msrh_rename_ckpt_map_pkg::*;
#(
  parameter int RNID_W     = MSRH_RNID_W,
  parameter int ARCH_NUM   = MSRH_ARCH_NUM,
  parameter int CKPT_DEPTH = MSRH_CKPT_DEPTH,
  parameter int CKPT_W     = $clog2(CKPT_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              alloc,
  input  logic [RNID_W-1:0] alloc_map [ARCH_NUM],
  input  logic              ckpt_release,
  input  logic              flush_ckpt_valid,
  input  logic [CKPT_W-1:0] flush_ckpt_id,
  input  logic              flush_all,
  output logic [RNID_W-1:0] restore_map [ARCH_NUM],
  output logic [CKPT_W-1:0] tail,
  output logic [CKPT_W:0]   count,
  output logic              full
);

  logic [RNID_W-1:0] ckpt_mem_reg [CKPT_DEPTH][ARCH_NUM];
  logic [CKPT_W-1:0] head_reg, head_next;
  logic [CKPT_W-1:0] tail_reg, tail_next;
  logic [CKPT_W:0]   count_reg, count_next;
  logic [CKPT_W-1:0] flush_dist;

  // Storage carries no reset: a slot is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (alloc) begin
      for (int a = 0; a < ARCH_NUM; a++) begin
        ckpt_mem_reg[tail_reg][a] <= alloc_map[a];
      end
    end
  end

  for (genvar gi = 0; gi < ARCH_NUM; gi++) begin : g_restore
    assign restore_map[gi] = ckpt_mem_reg[flush_ckpt_id][gi];
  end

  assign flush_dist = flush_ckpt_id - head_reg;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush_all) begin
      head_next  = tail_reg;
      count_next = '0;
    end else if (flush_ckpt_valid) begin
      // Keep the flushed checkpoint live and drop everything younger; a release lands after.
      tail_next  = flush_ckpt_id + 1'b1;
      count_next = {1'b0, flush_dist} + 1'b1;
      if (ckpt_release) begin
        head_next  = head_reg + 1'b1;
        count_next = {1'b0, flush_dist};
      end
    end else begin
      if (alloc) begin
        tail_next = tail_reg + 1'b1;
      end
      if (ckpt_release) begin
        head_next = head_reg + 1'b1;
      end
      case ({alloc, ckpt_release})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign tail  = tail_reg;
  assign count = count_reg;
  assign full  = (count_reg == (CKPT_W+1)'(CKPT_DEPTH));

endmodule

// File: rtl/msrh_rename_ckpt_map.sv
// Rename map table with intra-group forwarding, checkpoint ring recovery and a committed map.
// Optional simulation checkers and state dump are enabled by MSRH_RENAME_CKPT_CHECK_EN.
module msrh_rename_ckpt_map
  import msrh_rename_ckpt_map_pkg::*;
#(
  parameter int DISP_SIZE  = MSRH_DISP_SIZE,
  parameter int RNID_W     = MSRH_RNID_W,
  parameter int ARCH_NUM   = MSRH_ARCH_NUM,
  parameter int CKPT_DEPTH = MSRH_CKPT_DEPTH,
  parameter int CKPT_W     = $clog2(CKPT_DEPTH)
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_disp_valid,
  output logic                              o_disp_ready,
  input  logic                              i_ckpt_req,
  input  logic [DISP_SIZE*2*MSRH_REG_W-1:0] i_rs_regidx,
  input  logic [DISP_SIZE-1:0]              i_rd_valid,
  input  logic [DISP_SIZE*MSRH_REG_W-1:0]   i_rd_regidx,
  input  logic [DISP_SIZE*RNID_W-1:0]       i_rd_rnid,
  output logic [DISP_SIZE*2*RNID_W-1:0]     o_rs_rnid,
  output logic [DISP_SIZE*RNID_W-1:0]       o_rd_old_rnid,
  output logic [CKPT_W-1:0]                 o_ckpt_id,
  input  logic                              i_ckpt_release,
  input  logic                              i_flush_ckpt_valid,
  input  logic [CKPT_W-1:0]                 i_flush_ckpt_id,
  input  logic                              i_flush_all,
  input  logic [DISP_SIZE-1:0]              i_cmt_valid,
  input  logic [DISP_SIZE*MSRH_REG_W-1:0]   i_cmt_regidx,
  input  logic [DISP_SIZE*RNID_W-1:0]       i_cmt_rnid,
  output logic [CKPT_W:0]                   o_ckpt_count
);

  logic [MSRH_REG_W-1:0] rs_idx  [DISP_SIZE*2];
  logic [MSRH_REG_W-1:0] rd_idx  [DISP_SIZE];
  logic [MSRH_REG_W-1:0] cmt_idx [DISP_SIZE];
  logic [RNID_W-1:0]     rd_rnid [DISP_SIZE];
  logic [RNID_W-1:0]     cmt_rnid[DISP_SIZE];

  logic [RNID_W-1:0] spec_map_reg   [ARCH_NUM];
  logic [RNID_W-1:0] spec_map_next  [ARCH_NUM];
  logic [RNID_W-1:0] commit_map_reg [ARCH_NUM];
  logic [RNID_W-1:0] commit_map_next[ARCH_NUM];
  logic [RNID_W-1:0] grp_map        [ARCH_NUM];
  logic [RNID_W-1:0] restore_map    [ARCH_NUM];

  logic              accept;
  logic [CKPT_W-1:0] ckpt_tail;
  logic [CKPT_W:0]   ckpt_count;
  logic              ckpt_full;

  for (genvar gi = 0; gi < DISP_SIZE; gi++) begin : g_unpack
    assign rs_idx[2*gi]   = i_rs_regidx[(2*gi)*MSRH_REG_W +: MSRH_REG_W];
    assign rs_idx[2*gi+1] = i_rs_regidx[(2*gi+1)*MSRH_REG_W +: MSRH_REG_W];
    assign rd_idx[gi]     = i_rd_regidx[gi*MSRH_REG_W +: MSRH_REG_W];
    assign rd_rnid[gi]    = i_rd_rnid[gi*RNID_W +: RNID_W];
    assign cmt_idx[gi]    = i_cmt_regidx[gi*MSRH_REG_W +: MSRH_REG_W];
    assign cmt_rnid[gi]   = i_cmt_rnid[gi*RNID_W +: RNID_W];
  end

  // Ready never depends on release, so a full ring stays blocked for the releasing cycle.
  assign o_disp_ready = !i_flush_all && !i_flush_ckpt_valid && !(i_ckpt_req && ckpt_full);
  assign accept       = i_disp_valid && o_disp_ready;
  assign o_ckpt_id    = ckpt_tail;
  assign o_ckpt_count = ckpt_count;

  // Later slots overwrite earlier ones, so the youngest older producer wins.
  for (genvar gi = 0; gi < DISP_SIZE; gi++) begin : g_lookup
    logic [RNID_W-1:0] rs1_rnid, rs2_rnid, old_rnid;
    always_comb begin
      rs1_rnid = spec_map_reg[rs_idx[2*gi]];
      rs2_rnid = spec_map_reg[rs_idx[2*gi+1]];
      old_rnid = spec_map_reg[rd_idx[gi]];
      for (int p = 0; p < gi; p++) begin
        if (rn_fwd_lookup(i_rd_valid[p], rd_idx[p], rs_idx[2*gi]))   rs1_rnid = rd_rnid[p];
        if (rn_fwd_lookup(i_rd_valid[p], rd_idx[p], rs_idx[2*gi+1])) rs2_rnid = rd_rnid[p];
        if (rn_fwd_lookup(i_rd_valid[p], rd_idx[p], rd_idx[gi]))     old_rnid = rd_rnid[p];
      end
      if (rs_idx[2*gi] == '0)   rs1_rnid = '0;
      if (rs_idx[2*gi+1] == '0) rs2_rnid = '0;
      if (rd_idx[gi] == '0)     old_rnid = '0;
    end
    assign o_rs_rnid[(2*gi)*RNID_W +: RNID_W]   = rs1_rnid;
    assign o_rs_rnid[(2*gi+1)*RNID_W +: RNID_W] = rs2_rnid;
    assign o_rd_old_rnid[gi*RNID_W +: RNID_W]   = old_rnid;
  end

  always_comb begin
    for (int a = 0; a < ARCH_NUM; a++) begin
      grp_map[a]         = spec_map_reg[a];
      commit_map_next[a] = commit_map_reg[a];
    end
    for (int d = 0; d < DISP_SIZE; d++) begin
      if (i_rd_valid[d] && (rd_idx[d] != '0)) grp_map[rd_idx[d]] = rd_rnid[d];
      if (i_cmt_valid[d] && (cmt_idx[d] != '0)) commit_map_next[cmt_idx[d]] = cmt_rnid[d];
    end
  end

  always_comb begin
    for (int a = 0; a < ARCH_NUM; a++) begin
      if (i_flush_all)             spec_map_next[a] = commit_map_next[a];
      else if (i_flush_ckpt_valid) spec_map_next[a] = restore_map[a];
      else if (accept)             spec_map_next[a] = grp_map[a];
      else                         spec_map_next[a] = spec_map_reg[a];
    end
  end

  for (genvar gi = 0; gi < ARCH_NUM; gi++) begin : g_map
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        spec_map_reg[gi]   <= RNID_W'(gi);
        commit_map_reg[gi] <= RNID_W'(gi);
      end else begin
        spec_map_reg[gi]   <= spec_map_next[gi];
        commit_map_reg[gi] <= commit_map_next[gi];
      end
    end
  end

  msrh_rename_ckpt_ring #(
    .RNID_W    (RNID_W),
    .ARCH_NUM  (ARCH_NUM),
    .CKPT_DEPTH(CKPT_DEPTH),
    .CKPT_W    (CKPT_W)
  ) u_ring (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .alloc           (accept && i_ckpt_req),
    .alloc_map       (grp_map),
    .ckpt_release    (i_ckpt_release),
    .flush_ckpt_valid(i_flush_ckpt_valid),
    .flush_ckpt_id   (i_flush_ckpt_id),
    .flush_all       (i_flush_all),
    .restore_map     (restore_map),
    .tail            (ckpt_tail),
    .count           (ckpt_count),
    .full            (ckpt_full)
  );

`ifdef MSRH_RENAME_CKPT_CHECK_EN
  localparam int PAYLOAD_W = DISP_SIZE*2*MSRH_REG_W + DISP_SIZE + DISP_SIZE*MSRH_REG_W + DISP_SIZE*RNID_W;
  logic [PAYLOAD_W-1:0] chk_payload, chk_payload_reg;
  logic                 chk_stall_reg;
  logic [CKPT_W-1:0]    chk_age;

  assign chk_payload = {i_rs_regidx, i_rd_valid, i_rd_regidx, i_rd_rnid};
  // Live ids are the count entries counting back from tail-1.
  assign chk_age = ckpt_tail - 1'b1 - i_flush_ckpt_id;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      chk_stall_reg   <= 1'b0;
      chk_payload_reg <= '0;
    end else begin
      chk_stall_reg   <= i_disp_valid && !o_disp_ready && i_ckpt_req;
      chk_payload_reg <= chk_payload;
    end
  end

  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (i_ckpt_release && (ckpt_count == '0))
        $error("rename_ckpt: release with empty ring");
      if (i_flush_ckpt_valid && !i_flush_all && ({1'b0, chk_age} >= ckpt_count))
        $error("rename_ckpt: flush to non-live checkpoint %0d", i_flush_ckpt_id);
      if (chk_stall_reg && i_disp_valid && i_ckpt_req && (chk_payload != chk_payload_reg))
        $error("rename_ckpt: stalled group payload changed");
      if (i_flush_all && i_flush_ckpt_valid)
        $error("rename_ckpt: flush_all and flush_ckpt together");
    end
  end

  task automatic dump_json();
    $display("\"rename_ckpt_map\": {");
    $display("  \"ckpt_count\": %0d, \"ckpt_tail\": %0d,", ckpt_count, ckpt_tail);
    for (int a = 0; a < ARCH_NUM; a++)
      $display("  \"spec_%0d\": %0d, \"commit_%0d\": %0d,", a, spec_map_reg[a], a, commit_map_reg[a]);
    $display("  \"arch_num\": %0d", ARCH_NUM);
    $display("}");
  endtask

  final dump_json();
`endif

endmodule

// File: tb/tb_msrh_rename_ckpt_map.sv
// Directed bench for the rename map: forwarding, WAW, ring full/wrap, checkpoint and full flush.
module tb_msrh_rename_ckpt_map;

  localparam int DISP = 2;
  localparam int RW   = 7;
  localparam int CW   = 2;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_disp_valid;
  logic              o_disp_ready;
  logic              i_ckpt_req;
  logic [DISP*10-1:0] i_rs_regidx;
  logic [DISP-1:0]   i_rd_valid;
  logic [DISP*5-1:0] i_rd_regidx;
  logic [DISP*RW-1:0] i_rd_rnid;
  logic [DISP*2*RW-1:0] o_rs_rnid;
  logic [DISP*RW-1:0] o_rd_old_rnid;
  logic [CW-1:0]     o_ckpt_id;
  logic              i_ckpt_release;
  logic              i_flush_ckpt_valid;
  logic [CW-1:0]     i_flush_ckpt_id;
  logic              i_flush_all;
  logic [DISP-1:0]   i_cmt_valid;
  logic [DISP*5-1:0] i_cmt_regidx;
  logic [DISP*RW-1:0] i_cmt_rnid;
  logic [CW:0]       o_ckpt_count;

  int tests_run;
  int tests_failed;

  msrh_rename_ckpt_map dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_disp_valid      (i_disp_valid),
    .o_disp_ready      (o_disp_ready),
    .i_ckpt_req        (i_ckpt_req),
    .i_rs_regidx       (i_rs_regidx),
    .i_rd_valid        (i_rd_valid),
    .i_rd_regidx       (i_rd_regidx),
    .i_rd_rnid         (i_rd_rnid),
    .o_rs_rnid         (o_rs_rnid),
    .o_rd_old_rnid     (o_rd_old_rnid),
    .o_ckpt_id         (o_ckpt_id),
    .i_ckpt_release    (i_ckpt_release),
    .i_flush_ckpt_valid(i_flush_ckpt_valid),
    .i_flush_ckpt_id   (i_flush_ckpt_id),
    .i_flush_all       (i_flush_all),
    .i_cmt_valid       (i_cmt_valid),
    .i_cmt_regidx      (i_cmt_regidx),
    .i_cmt_rnid        (i_cmt_rnid),
    .o_ckpt_count      (o_ckpt_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic idle();
    i_disp_valid = 1'b0; i_ckpt_req = 1'b0; i_rs_regidx = '0;
    i_rd_valid = '0; i_rd_regidx = '0; i_rd_rnid = '0;
    i_ckpt_release = 1'b0; i_flush_ckpt_valid = 1'b0; i_flush_ckpt_id = '0;
    i_flush_all = 1'b0; i_cmt_valid = '0; i_cmt_regidx = '0; i_cmt_rnid = '0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rs(input int d, input int s, input int idx);
    i_rs_regidx[(2*d+s)*5 +: 5] = 5'(idx);
  endtask

  task automatic set_rd(input int d, input int idx, input int rnid);
    i_rd_valid[d] = 1'b1;
    i_rd_regidx[d*5 +: 5] = 5'(idx);
    i_rd_rnid[d*RW +: RW] = RW'(rnid);
  endtask

  task automatic set_cmt(input int d, input int idx, input int rnid);
    i_cmt_valid[d] = 1'b1;
    i_cmt_regidx[d*5 +: 5] = 5'(idx);
    i_cmt_rnid[d*RW +: RW] = RW'(rnid);
  endtask

  function automatic int rs_out(input int d, input int s);
    return int'(o_rs_rnid[(2*d+s)*RW +: RW]);
  endfunction

  function automatic int old_out(input int d);
    return int'(o_rd_old_rnid[d*RW +: RW]);
  endfunction

  // Map read-back via slot 0 rs1 with no dispatch in flight.
  task automatic look(input string tag, input int x, input int exp);
    idle();
    set_rs(0, 0, x);
    #1;
    check(tag, rs_out(0, 0), exp);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    i_reset_n = 1'b0;
    idle();
    set_rs(0, 0, 5);
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_ready", int'(o_disp_ready), 1);
    check("reset_ckpt_id", int'(o_ckpt_id), 0);
    check("reset_count", int'(o_ckpt_count), 0);
    check("reset_identity_x5", rs_out(0, 0), 5);
    i_reset_n = 1'b1;
    step();

    // Forwarding within a group
    idle();
    i_disp_valid = 1'b1;
    set_rs(0, 0, 1); set_rs(0, 1, 2); set_rd(0, 5, 40);
    set_rs(1, 0, 5); set_rs(1, 1, 5); set_rd(1, 6, 41);
    #1;
    check("fwd_s1_rs1", rs_out(1, 0), 40);
    check("fwd_s1_rs2", rs_out(1, 1), 40);
    check("fwd_s0_rs1", rs_out(0, 0), 1);
    check("fwd_old0", old_out(0), 5);
    check("fwd_old1", old_out(1), 6);
    step();
    look("map_x5", 5, 40);
    look("map_x6", 6, 41);

    // Same-group WAW
    idle();
    i_disp_valid = 1'b1;
    set_rd(0, 7, 50); set_rd(1, 7, 51);
    #1;
    check("waw_old0", old_out(0), 7);
    check("waw_old1", old_out(1), 50);
    step();
    look("waw_map_x7", 7, 51);

    // Fill the ring, stall, release and wrap
    for (int g = 0; g < 4; g++) begin
      idle();
      i_disp_valid = 1'b1; i_ckpt_req = 1'b1;
      #1;
      check($sformatf("fill_id%0d", g), int'(o_ckpt_id), g);
      step();
    end
    idle(); #1;
    check("full_count", int'(o_ckpt_count), 4);
    i_disp_valid = 1'b1; i_ckpt_req = 1'b1; i_ckpt_release = 1'b1;
    #1;
    check("full_ready_with_release", int'(o_disp_ready), 0);
    step();
    idle();
    i_disp_valid = 1'b1; i_ckpt_req = 1'b1;
    #1;
    check("after_release_ready", int'(o_disp_ready), 1);
    check("wrap_ckpt_id", int'(o_ckpt_id), 0);
    check("after_release_count", int'(o_ckpt_count), 3);
    step();
    idle(); #1;
    check("refill_count", int'(o_ckpt_count), 4);
    i_flush_all = 1'b1;
    step();
    idle(); #1;
    check("flushall_count", int'(o_ckpt_count), 0);
    i_disp_valid = 1'b1; i_ckpt_req = 1'b1;
    step();
    idle();
    i_disp_valid = 1'b1; i_ckpt_req = 1'b1; i_ckpt_release = 1'b1;
    step();
    idle(); #1;
    check("alloc_rel_count", int'(o_ckpt_count), 1);
    check("alloc_rel_id", int'(o_ckpt_id), 3);

    // Checkpoint restore after a fresh reset
    i_reset_n = 1'b0;
    #2;
    check("rst2_count", int'(o_ckpt_count), 0);
    i_reset_n = 1'b1;
    look("rst2_map_x5", 5, 5);
    idle(); i_disp_valid = 1'b1; i_ckpt_req = 1'b1;
    step();
    idle(); i_disp_valid = 1'b1; i_ckpt_req = 1'b1; set_rd(0, 3, 60);
    step();
    idle(); i_disp_valid = 1'b1; i_ckpt_req = 1'b1; set_rd(0, 3, 70);
    step();
    look("pre_flush_x3", 3, 70);
    check("pre_flush_count", int'(o_ckpt_count), 3);
    idle();
    i_flush_ckpt_valid = 1'b1; i_flush_ckpt_id = 2'd1;
    i_disp_valid = 1'b1; set_rd(0, 12, 90);
    #1;
    check("flushck_ready", int'(o_disp_ready), 0);
    step();
    look("flushck_x3", 3, 60);
    check("flushck_count", int'(o_ckpt_count), 2);
    check("flushck_next_id", int'(o_ckpt_id), 2);
    look("flushck_blocked_x12", 12, 12);

    // Committed map and full flush
    idle(); set_cmt(0, 9, 33);
    step();
    look("cmt_spec_x9", 9, 9);
    idle(); i_disp_valid = 1'b1; set_rd(0, 9, 80);
    step();
    look("spec_x9", 9, 80);
    idle();
    i_flush_all = 1'b1; i_disp_valid = 1'b1; set_rd(0, 11, 90);
    set_cmt(0, 10, 35); set_cmt(1, 10, 34);
    #1;
    check("flushall_ready", int'(o_disp_ready), 0);
    step();
    look("flushall_x9", 9, 33);
    look("flushall_x10", 10, 34);
    look("flushall_x11", 11, 11);
    look("flushall_x3", 3, 3);
    check("flushall2_count", int'(o_ckpt_count), 0);
    check("flushall2_id", int'(o_ckpt_id), 2);

    // x0 destination and source
    idle();
    i_disp_valid = 1'b1;
    set_rd(0, 0, 99); set_rs(1, 0, 0); set_rs(1, 1, 9);
    #1;
    check("x0_rs", rs_out(1, 0), 0);
    check("x0_old", old_out(0), 0);
    check("x0_other_rs", rs_out(1, 1), 33);
    step();
    look("x0_map", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/msrh_rename_ckpt_map.md
Name: msrh_rename_ckpt_map

Overview:
Parametrised rename map table with multi-checkpoint branch recovery. It sits between the decode queue and the scheduler dispatch register.
- Renames DISP_SIZE instructions per cycle with intra-group forwarding.
- Snapshots the speculative map into a ring of CKPT_DEPTH checkpoints for branch-containing groups.
- Restores either to a named checkpoint (mispredict) or to the committed map (full flush).
- Replaces the single-queue restore scheme with selective, depth-configurable recovery.

Parameters:
DISP_SIZE, 2, instructions renamed per cycle
RNID_W, 7, physical register id width
ARCH_NUM, 32, architectural registers (index 0 hardwired, never renamed)
CKPT_DEPTH, 4, checkpoint slots (power of two); CKPT_W = $clog2(CKPT_DEPTH)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  reset
i_disp_valid  in  1  dispatch group valid
o_disp_ready  out  1  group accepted this cycle
i_ckpt_req  in  1  group contains a branch; allocate a checkpoint
i_rs_regidx  in  DISP_SIZE*2*5  source arch ids; slot d rs1 at [2d], rs2 at [2d+1]
i_rd_valid  in  DISP_SIZE  slot writes rd
i_rd_regidx  in  DISP_SIZE*5  dest arch ids
i_rd_rnid  in  DISP_SIZE*RNID_W  new phys ids from freelist
o_rs_rnid  out  DISP_SIZE*2*RNID_W  renamed sources
o_rd_old_rnid  out  DISP_SIZE*RNID_W  previous mapping of rd, freed at commit
o_ckpt_id  out  CKPT_W  checkpoint id given to this group
i_ckpt_release  in  1  oldest checkpoint's branch committed
i_flush_ckpt_valid  in  1  mispredict; restore to checkpoint
i_flush_ckpt_id  in  CKPT_W  checkpoint to restore
i_flush_all  in  1  exception/full flush; restore committed map
i_cmt_valid  in  DISP_SIZE  committing slot writes rd
i_cmt_regidx  in  DISP_SIZE*5  committed rd arch id
i_cmt_rnid  in  DISP_SIZE*RNID_W  committed rd phys id
o_ckpt_count  out  CKPT_W+1  live checkpoints

Behaviour:
- Clock/reset: i_clk, single clock domain; i_reset_n asynchronous, active-low.
- Reset state: spec_map[i] = commit_map[i] = i; head = tail = 0; count = 0.
- Reset outputs: o_disp_ready = 1, o_ckpt_id = 0, o_ckpt_count = 0, o_rs_rnid = identity lookup.
- Architectural register 0:
  - rd_regidx == 0 is treated as rd_valid = 0: no map update, no forwarding, o_rd_old_rnid = 0.
  - rs_regidx == 0 always yields rnid 0.
- Source lookup (combinational): slot d source = i_rd_rnid of the youngest slot p < d with rd valid and the same regidx; otherwise spec_map.
- o_rd_old_rnid[d] (combinational): youngest earlier same-rd slot's i_rd_rnid; otherwise spec_map.
- o_disp_ready = !i_flush_all && !i_flush_ckpt_valid && !(i_ckpt_req && count == CKPT_DEPTH).
  - A release in the same cycle does not unblock a full ring; no combinational path from release to ready.
- Accept = i_disp_valid && o_disp_ready.
  - On accept, spec_map updates at the next edge; higher slot wins on same-group WAW.
  - Lookups made in the same cycle see the old map plus forwarding.
- Checkpoint write: if accept && i_ckpt_req, ckpt[tail] <= map after applying the whole group; tail++ (wraps mod CKPT_DEPTH); count++.
- o_ckpt_id = tail (combinational); meaningful only when a checkpoint is allocated.
- i_ckpt_release: head++, count--. Simultaneous allocate + release leaves count unchanged.
- i_flush_ckpt_valid with id k:
  - spec_map <= ckpt[k]; checkpoint k stays live; all younger checkpoints are discarded.
  - tail <= k+1; count <= ((k - head) mod CKPT_DEPTH) + 1.
  - A release in the same cycle is applied after the truncation.
- i_flush_all:
  - spec_map <= commit_map (including the same-cycle i_cmt updates); head = tail; count = 0.
  - Overrides i_flush_ckpt_valid and release.
- Priority: flush_all > flush_ckpt > dispatch. Dispatch is always blocked in a flush cycle.
- Commit map: updates every cycle from i_cmt_*, higher slot wins, regidx 0 ignored. Independent of flushes; a flush never blocks commit.
- Release or flush on an empty ring, or a flush to a non-live id, is illegal; hardware state is undefined but must not hang.

Optional Feature:
MSRH_RENAME_CKPT_CHECK_EN:
- When defined, simulation-only checkers flag these with $error:
  - release with count == 0
  - flush id outside head..tail-1
  - i_disp_valid && !o_disp_ready && i_ckpt_req held with a changing payload
  - i_flush_all and i_flush_ckpt_valid asserted together
- The checkers also emit a dump_json section with the map and checkpoint state.
- When undefined, no checker logic exists and the RTL is identical otherwise.

Decomposition:
- msrh_pkg gains:
  - RNID_W usage
  - CKPT_DEPTH / CKPT_W constants
  - typedef rn_map_t (ARCH_NUM x RNID_W array)
  - function rn_fwd_lookup for intra-group forwarding
- One sub-module, msrh_rename_ckpt_ring: checkpoint storage plus head/tail/count pointer logic and the truncate/flush rules.

Test Plan:
- Reset then group {add x5 (rd rnid 40), sub x6,x5,x5 (rd rnid 41)} -> slot1 rs1/rs2 = 40, o_rd_old_rnid = {5,6}; next cycle lookup x5 = 40, x6 = 41.
- Same-group WAW x7 -> 50 then x7 -> 51 -> o_rd_old_rnid slot1 = 50; map x7 = 51 afterwards.
- Four branch groups with CKPT_DEPTH = 4, fifth with i_ckpt_req -> o_disp_ready = 0; after release, ready = 1 and o_ckpt_id = 0 (wrap).
- Checkpoints 0..2 live, x3 -> 60 in ckpt1 and -> 70 after; flush id 1 -> x3 = 60, o_ckpt_count = 2, next o_ckpt_id = 2.
- Commit x9 -> 33 then speculate x9 -> 80; i_flush_all -> x9 = 33, count = 0; dispatch blocked in the flush cycle.
- rd = x0 with rnid 99 and rs = x0 in the next slot -> rs rnid 0, no map change, o_rd_old_rnid = 0.
